// File: rtl/booth_datapath_if.sv
// Booth datapath bus: operand inputs, control strobes from the FSM,
// decision bits and product back out.
interface booth_datapath_if #(
  parameter int N = 8
);
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic           load_add;
  logic           load_A;
  logic           load_B;
  logic           shift_HQ_LQ_Q_1;
  logic           add_sub;
  logic           Q_LSQ_1;
  logic           Q_LSQ_0;
  logic [2*N-1:0] product;
  logic           done;

  modport master (
    output multiplicand, multiplier,
    output load_add, load_A, load_B,
    output shift_HQ_LQ_Q_1, add_sub,
    input  Q_LSQ_1, Q_LSQ_0,
    input  product, done
  );

  modport slave (
    input  multiplicand, multiplier,
    input  load_add, load_A, load_B,
    input  shift_HQ_LQ_Q_1, add_sub,
    output Q_LSQ_1, Q_LSQ_0,
    output product, done
  );
endinterface

// File: rtl/booth_datapath.sv
// Radix-2 Booth multiplier datapath: M, HQ (guard bit), LQ, Q_1,
// iteration counter and done flag, stepped by FSM strobes.
module booth_datapath #(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic              clk,
  input  logic              rst,
  booth_datapath_if.slave   bus
);

  logic [N-1:0]  m_q, m_d;
  logic [N:0]    hq_q, hq_d;
  logic [N-1:0]  lq_q, lq_d;
  logic          q1_q, q1_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  logic [N:0]    m_ext;
  logic [N:0]    sum;
  logic [N:0]    src;
  logic [CW-1:0] cnt_inc;

  // Guard bit keeps HQ - (-2^(N-1)) representable.
  assign m_ext   = {m_q[N-1], m_q};
  assign sum     = bus.add_sub ? hq_q + m_ext
                               : hq_q - m_ext;
  assign src     = bus.load_add ? sum : hq_q;
  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    m_d    = m_q;
    hq_d   = hq_q;
    lq_d   = lq_q;
    q1_d   = q1_q;
    cnt_d  = cnt_q;
    done_d = done_q;
    if (bus.load_B) begin
      m_d    = bus.multiplicand;
      hq_d   = '0;
      lq_d   = bus.multiplier;
      q1_d   = 1'b0;
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (bus.load_A && !done_q) begin
      if (bus.shift_HQ_LQ_Q_1) begin
        hq_d  = {src[N], src[N:1]};
        lq_d  = {src[0], lq_q[N-1:1]};
        q1_d  = lq_q[0];
        cnt_d = cnt_inc;
        if (cnt_inc == CW'(N))
          done_d = 1'b1;
      end else if (bus.load_add) begin
        hq_d = sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q    <= '0;
      hq_q   <= '0;
      lq_q   <= '0;
      q1_q   <= 1'b0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      m_q    <= m_d;
      hq_q   <= hq_d;
      lq_q   <= lq_d;
      q1_q   <= q1_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign bus.Q_LSQ_1 = lq_q[0];
  assign bus.Q_LSQ_0 = q1_q;
  assign bus.product = {hq_q[N-1:0], lq_q};
  assign bus.done    = done_q;

endmodule
